// File: rtl/regfile_pkg.sv
// Shared register-file constants and types, used by the write-back path
// and by the read-side transpose / mux blocks.
package regfile_pkg;

    localparam int NUM_REGS = 32;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 64;
    localparam int ZERO_REG = 31;

    typedef logic [ADDR_W-1:0] reg_addr_t;

endpackage : regfile_pkg

// File: rtl/regfile_write_back_decoder.sv
// Index-to-one-hot decoder that produces the per-register write enables.
module decoder5to32
    import regfile_pkg::*;
(
    input  reg_addr_t             idx_i,
    input  logic                  en_i,
    output logic [NUM_REGS-1:0]   onehot_o
);

    always_comb begin
        onehot_o = '0;
        if (en_i) begin
            onehot_o[idx_i] = 1'b1;
        end
    end

endmodule : decoder5to32

// File: rtl/regfile_write_back.sv
// Two-step register-file write-back: requests are captured in a one-entry
// latch on one edge and committed to the 32-entry storage on the next.
module regfile_write_back #(
    parameter int DATA_W   = regfile_pkg::DATA_W,
    parameter int ZERO_REG = regfile_pkg::ZERO_REG
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic                                        wr_en,
    input  regfile_pkg::reg_addr_t                      wr_addr,
    input  logic [DATA_W-1:0]                           wr_data,
    input  logic                                        stall,
    output logic [regfile_pkg::NUM_REGS-1:0][DATA_W-1:0] read_list,
    output logic                                        pend_valid,
    output regfile_pkg::reg_addr_t                      pend_addr,
    output logic [DATA_W-1:0]                           pend_data
);

    localparam int                     NUM_REGS = regfile_pkg::NUM_REGS;
    localparam regfile_pkg::reg_addr_t ZERO_IDX = regfile_pkg::reg_addr_t'(ZERO_REG);

    logic                   pend_valid_q, pend_valid_d;
    regfile_pkg::reg_addr_t pend_addr_q,  pend_addr_d;
    logic [DATA_W-1:0]      pend_data_q,  pend_data_d;
    logic [NUM_REGS-1:0]    wr_sel;
    logic                   commit_en;

    // Writes to the zero register are dropped here so they never reach storage.
    always_comb begin
        pend_valid_d = wr_en && (wr_addr != ZERO_IDX);
        pend_addr_d  = wr_addr;
        pend_data_d  = wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_valid_q <= 1'b0;
            pend_addr_q  <= '0;
            pend_data_q  <= '0;
        end else if (!stall) begin
            pend_valid_q <= pend_valid_d;
            pend_addr_q  <= pend_addr_d;
            pend_data_q  <= pend_data_d;
        end
    end

    assign commit_en = pend_valid_q && !stall;

    decoder5to32 u_decoder (
        .idx_i    (pend_addr_q),
        .en_i     (commit_en),
        .onehot_o (wr_sel)
    );

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
        if (i == ZERO_REG) begin : g_zero
            // Enable for this slot can never fire; kept only to consume the bit.
            logic zero_sel_unused;
            assign zero_sel_unused = wr_sel[i];
            assign read_list[i]    = '0;
        end else begin : g_flop
            logic [DATA_W-1:0] reg_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    reg_q <= '0;
                end else if (wr_sel[i]) begin
                    reg_q <= pend_data_q;
                end
            end

            assign read_list[i] = reg_q;
        end
    end

    assign pend_valid = pend_valid_q;
    assign pend_addr  = pend_addr_q;
    assign pend_data  = pend_data_q;

endmodule : regfile_write_back

// File: tb/tb_regfile_write_back.sv
// Bench for regfile_write_back: directed vector table plus randomized traffic
// against a pending-slot / register-array reference model.
module tb_regfile_write_back;

    logic                   clk = 1'b0;
    logic                   reset;
    logic                   wr_en;
    logic [4:0]             wr_addr;
    logic [63:0]            wr_data;
    logic                   stall;
    logic [31:0][63:0]      read_list;
    logic                   pend_valid;
    logic [4:0]             pend_addr;
    logic [63:0]            pend_data;

    int n_vec  = 0;
    int n_miss = 0;

    regfile_write_back #(.DATA_W(64), .ZERO_REG(31)) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .stall      (stall),
        .read_list  (read_list),
        .pend_valid (pend_valid),
        .pend_addr  (pend_addr),
        .pend_data  (pend_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        we;
        logic [4:0]  wa;
        logic [63:0] wd;
        logic        exp_pv;
        logic        chk_p;
        logic [4:0]  exp_pa;
        logic [63:0] exp_pd;
        int          idx;
        logic [63:0] exp_rd;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic stl, logic we, logic [4:0] wa,
                                logic [63:0] wd, logic exp_pv, logic chk_p,
                                logic [4:0] exp_pa, logic [63:0] exp_pd,
                                int idx, logic [63:0] exp_rd);
        vec_t v;
        v.rst = rst; v.stl = stl; v.we = we; v.wa = wa; v.wd = wd;
        v.exp_pv = exp_pv; v.chk_p = chk_p; v.exp_pa = exp_pa; v.exp_pd = exp_pd;
        v.idx = idx; v.exp_rd = exp_rd;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Drive inputs after the falling edge, let one rising edge pass, sample 1ns later.
    task automatic cycle(input logic rst, input logic stl, input logic we,
                         input logic [4:0] wa, input logic [63:0] wd);
        @(negedge clk);
        reset   = rst;
        stall   = stl;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    logic [63:0] m_mem [32];
    logic        m_pv;
    logic [4:0]  m_pa;
    logic [63:0] m_pd;

    task automatic model_edge(input logic rst, input logic stl, input logic we,
                              input logic [4:0] wa, input logic [63:0] wd);
        if (rst) begin
            foreach (m_mem[k]) m_mem[k] = '0;
            m_pv = 1'b0; m_pa = '0; m_pd = '0;
        end else if (!stl) begin
            if (m_pv) m_mem[m_pa] = m_pd;
            m_pv = we && (wa != 5'd31);
            m_pa = wa;
            m_pd = wd;
        end
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;

        cycle(1'b1, 1'b0, 1'b0, 5'd0, 64'd0);
        cycle(1'b1, 1'b0, 1'b0, 5'd0, 64'd0);
        check("init_pend_valid", {63'd0, pend_valid}, 64'd0);
        for (int i = 0; i < 32; i++) check($sformatf("init_reg%0d", i), read_list[i], 64'd0);

        //            rst   stl   we    wa     wd                         pv    chkp  pa     pd                    idx exp_rd
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 5'd4,  64'hAA,                   1'b1, 1'b1, 5'd4,  64'hAA,                   4, 64'h0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 5'd6,  64'hBB,                   1'b1, 1'b0, 5'd0,  64'h0,                    4, 64'hAA));
        vecs.push_back(mk(1'b1, 1'b0, 1'b1, 5'd8,  64'hCC,                   1'b0, 1'b1, 5'd0,  64'h0,                    6, 64'h0));
        vecs.push_back(mk(1'b1, 1'b1, 1'b0, 5'd0,  64'h0,                    1'b0, 1'b1, 5'd0,  64'h0,                    4, 64'h0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 5'd5,  64'hDEAD_BEEF_0000_0005,  1'b1, 1'b1, 5'd5,  64'hDEAD_BEEF_0000_0005,  5, 64'h0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 5'd2,  64'h123,                  1'b0, 1'b0, 5'd0,  64'h0,                    5, 64'hDEAD_BEEF_0000_0005));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 5'd0,  64'h0,                    1'b0, 1'b0, 5'd0,  64'h0,                    2, 64'h0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF,  1'b0, 1'b0, 5'd0,  64'h0,                   31, 64'h0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 5'd0,  64'h0,                    1'b0, 1'b0, 5'd0,  64'h0,                   31, 64'h0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 5'd3,  64'h11,                   1'b1, 1'b1, 5'd3,  64'h11,                   3, 64'h0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 5'd3,  64'h22,                   1'b1, 1'b1, 5'd3,  64'h22,                   3, 64'h11));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 5'd0,  64'h0,                    1'b0, 1'b0, 5'd0,  64'h0,                    3, 64'h22));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 5'd7,  64'h77,                   1'b1, 1'b1, 5'd7,  64'h77,                   7, 64'h0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 5'd7,  64'h55,                   1'b1, 1'b1, 5'd7,  64'h77,                   7, 64'h0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 5'd1,  64'h66,                   1'b1, 1'b1, 5'd7,  64'h77,                   7, 64'h0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b0, 5'd0,  64'h0,                    1'b1, 1'b1, 5'd7,  64'h77,                   1, 64'h0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 5'd0,  64'h0,                    1'b0, 1'b0, 5'd0,  64'h0,                    7, 64'h77));
        vecs.push_back(mk(1'b0, 1'b0, 1'b1, 5'd9,  64'h99,                   1'b1, 1'b1, 5'd9,  64'h99,                   9, 64'h0));
        vecs.push_back(mk(1'b1, 1'b0, 1'b0, 5'd0,  64'h0,                    1'b0, 1'b1, 5'd0,  64'h0,                    9, 64'h0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 5'd0,  64'h0,                    1'b0, 1'b0, 5'd0,  64'h0,                    9, 64'h0));
        vecs.push_back(mk(1'b0, 1'b1, 1'b1, 5'd10, 64'h1234,                 1'b0, 1'b0, 5'd0,  64'h0,                   10, 64'h0));
        vecs.push_back(mk(1'b0, 1'b0, 1'b0, 5'd0,  64'h0,                    1'b0, 1'b0, 5'd0,  64'h0,                   10, 64'h0));

        for (int v = 0; v < vecs.size(); v++) begin
            cycle(vecs[v].rst, vecs[v].stl, vecs[v].we, vecs[v].wa, vecs[v].wd);
            check($sformatf("vec%0d_pend_valid", v), {63'd0, pend_valid}, {63'd0, vecs[v].exp_pv});
            check($sformatf("vec%0d_reg%0d", v, vecs[v].idx), read_list[vecs[v].idx], vecs[v].exp_rd);
            check($sformatf("vec%0d_reg31", v), read_list[31], 64'd0);
            if (vecs[v].chk_p) begin
                check($sformatf("vec%0d_pend_addr", v), {59'd0, pend_addr}, {59'd0, vecs[v].exp_pa});
                check($sformatf("vec%0d_pend_data", v), pend_data, vecs[v].exp_pd);
            end
        end

        // Randomized traffic against the model, starting from a clean reset.
        cycle(1'b1, 1'b0, 1'b0, 5'd0, 64'd0);
        model_edge(1'b1, 1'b0, 1'b0, 5'd0, 64'd0);
        for (int c = 0; c < 400; c++) begin
            logic        r, s, we;
            logic [4:0]  a;
            logic [63:0] d;
            r  = ($urandom_range(0, 39) == 0);
            s  = ($urandom_range(0, 4) == 0);
            we = ($urandom_range(0, 3) != 0);
            a  = ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 31));
            d  = {$urandom, $urandom};
            cycle(r, s, we, a, d);
            model_edge(r, s, we, a, d);
            check($sformatf("rnd%0d_pend_valid", c), {63'd0, pend_valid}, {63'd0, m_pv});
            if (m_pv) begin
                check($sformatf("rnd%0d_pend_addr", c), {59'd0, pend_addr}, {59'd0, m_pa});
                check($sformatf("rnd%0d_pend_data", c), pend_data, m_pd);
            end
            for (int k = 0; k < 32; k++) begin
                check($sformatf("rnd%0d_reg%0d", c, k), read_list[k], m_mem[k]);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_regfile_write_back

// File: doc/regfile_write_back.md
REGFILE_WRITE_BACK -- requirements
Module: regfile_write_back

Interface
REQ-001 Parameter DATA_W, default 64: width of each register and of the write data.
REQ-002 Parameter ZERO_REG, default 31: index of the hardwired-zero register (XZR).
REQ-003 Port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1: reset is synchronous and active-high.
REQ-005 Port wr_en, input, 1: write-back request valid this cycle.
REQ-006 Port wr_addr, input, 5: destination register index, 0-31.
REQ-007 Port wr_data, input, DATA_W: write-back value.
REQ-008 Port stall, input, 1: freezes the write-back latch and blocks commit.
REQ-009 Port read_list, output, [31:0][DATA_W-1:0]: all 32 registers, packed with index = register number; feeds the read-side transpose and mux tree.
REQ-010 Port pend_valid, output, 1: a captured write is waiting to commit.
REQ-011 Port pend_addr, output, 5: destination index of the pending write.
REQ-012 Port pend_data, output, DATA_W: data of the pending write, for forwarding.

Function
REQ-013 Two-step write: request captured into the write-back latch at edge N, committed to storage at edge N+1.
REQ-014 The committed value shall appear on read_list after edge N+1, with no combinational path from wr_* to read_list.
REQ-015 At each edge with stall=0, pend_valid <= wr_en AND (wr_addr != ZERO_REG); pend_addr <= wr_addr; pend_data <= wr_data.
REQ-016 At each edge with stall=0 and pend_valid=1, register[pend_addr] <= pend_data; no other register changes.
REQ-017 With stall=1, the latch and all 32 registers hold; wr_* that cycle is ignored, and upstream re-presents the request.
REQ-018 Capture of a new request and commit of the pending one on the same edge are both performed.
REQ-019 Back-to-back writes to the same address: the later value wins, one cycle after the earlier one.
REQ-020 read_list[ZERO_REG] is constant 0; writes to ZERO_REG are discarded at capture and never raise pend_valid.
REQ-021 The address decode into 32 one-hot enables is qualified by pend_valid; at most one enable is active per cycle.
REQ-022 wr_en=0 leaves pend_valid=0 after the next unstalled edge; pend_addr and pend_data still load but are don't-care.

Reset
REQ-023 On a clk edge with reset=1, all 32 registers go to 0, pend_valid to 0, pend_addr to 0, and pend_data to 0.
REQ-024 Reset overrides stall and discards any pending write, including a reset asserted mid-operation between capture and commit.
REQ-025 On the first edge after reset deasserts, a request is captured normally; the earliest commit is the following edge.

Structure
REQ-026 The shared package regfile_pkg holds NUM_REGS=32, ADDR_W=5, DATA_W=64, ZERO_REG=31 and typedef reg_addr_t (logic [4:0]); the read-side blocks use the same package.
REQ-027 Sub-module decoder5to32 (5-bit index plus enable in, 32-bit one-hot out, combinational) generates the per-register write enables.
REQ-028 Storage is 32 DATA_W-wide registers built with a generate loop; the ZERO_REG slot is tied to 0 and has no flops.

Verification
REQ-029 Reset scenario: assert reset for 2 cycles after arbitrary writes -> all read_list entries are 0 and pend_valid=0.
REQ-030 Basic write: wr_en=1, wr_addr=5, wr_data=0xDEADBEEF_00000005 at edge N -> pend_valid=1 after N; read_list[5] equals that value after N+1; all other entries unchanged.
REQ-031 Zero register: wr_en=1, wr_addr=31, wr_data=0xFFFF_FFFF_FFFF_FFFF -> pend_valid stays 0 and read_list[31]=0 on every cycle.
REQ-032 Back-to-back writes: addr 3 = 0x11 then addr 3 = 0x22 on consecutive edges -> read_list[3] reads 0x11, then 0x22, one cycle apart.
REQ-033 Stall: pending write to addr 7 = 0x77 with stall=1 for 3 cycles -> read_list[7] is unchanged and pend_* are held; the commit lands on the first edge with stall=0.
REQ-034 Reset mid-operation: capture a write to addr 9 = 0x99, then assert reset on the next edge -> read_list[9]=0 and pend_valid=0.
